// File: rtl/mult_result_fifo_if.sv
// Handshake bundle between the shift-add multiplier, the result FIFO and its consumer.
// master: the producer/consumer side; slave: the FIFO itself.
interface mult_result_fifo_if #(
  parameter int DP_WIDTH = 5,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = $clog2(DEPTH + 1)
);
  logic                    rdy;
  logic [2*DP_WIDTH-1:0]   product;
  logic                    pop;
  logic [2*DP_WIDTH-1:0]   dout;
  logic                    empty;
  logic                    full;
  logic [CNT_W-1:0]        count;
  logic                    overflow;
  logic                    start_req;

  modport master (
    output rdy, product, pop,
    input  dout, empty, full, count, overflow, start_req
  );

  modport slave (
    input  rdy, product, pop,
    output dout, empty, full, count, overflow, start_req
  );
endinterface

// File: rtl/mult_result_fifo.sv
// Result FIFO behind the sequential shift-add multiplier.
// Captures each finished product (rising edge of rdy) into a show-ahead FIFO,
// throttles the multiplier through start_req, and flags dropped products.
// Optional running accumulator of accepted products: define MULT_ACCUM_EN.
module mult_result_fifo #(
  parameter int DP_WIDTH = 5,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = $clog2(DEPTH + 1),
  parameter int ACC_W    = 2*DP_WIDTH + 5
) (
  input  logic               clk,
  input  logic               rstb,
  mult_result_fifo_if.slave  bus
`ifdef MULT_ACCUM_EN
  ,
  input  logic               acc_clr,
  output logic [ACC_W-1:0]   acc
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PROD_W = 2*DP_WIDTH;

  logic [PROD_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_r, count_nxt;
  logic              rdy_d;
  logic              overflow_r;
  logic              empty_w, full_w;
  logic              cap, push, pop_ok;

  assign empty_w = (count_r == '0);
  assign full_w  = (count_r == CNT_W'(DEPTH));

  // Completion is the 0->1 edge of rdy; a push needs room, or a slot freed by a same-cycle pop.
  assign cap    = bus.rdy & ~rdy_d;
  assign pop_ok = bus.pop & ~empty_w;
  assign push   = cap & (~full_w | bus.pop);

  assign bus.dout      = mem[rd_ptr];
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.count     = count_r;
  assign bus.overflow  = overflow_r;
  assign bus.start_req = ~full_w;

  // Occupancy update from the push/pop combination.
  always_comb begin
    count_nxt = count_r;
    case ({push, pop_ok})
      2'b10:   count_nxt = count_r + CNT_W'(1);
      2'b01:   count_nxt = count_r - CNT_W'(1);
      default: count_nxt = count_r;
    endcase
  end

  // Control state: edge detector, pointers, occupancy and sticky overflow.
  // rdy_d resets high so a multiplier already idle at reset release is not taken as a completion.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rdy_d      <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      rdy_d   <= bus.rdy;
      count_r <= count_nxt;
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + PW'(1);
      if (cap & full_w & ~bus.pop)
        overflow_r <= 1'b1;
    end
  end

  // Storage array; data only, so no reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.product;
  end

`ifdef MULT_ACCUM_EN
  // Running sum of accepted products; clear wins over a coincident push.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      acc <= '0;
    else if (acc_clr)
      acc <= '0;
    else if (push)
      acc <= acc + {{(ACC_W-PROD_W){1'b0}}, bus.product};
  end
`endif

endmodule
